// File: rtl/pc_pkg.sv
// Shared definitions for the branch-target table: entry layout and legacy reset contents.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pc_pkg;

  // Entry width the legacy programs were built for. The top re-declares the same
  // layout at its own D so the table width follows the module parameter.
  localparam int PC_W = 12;

  typedef struct packed {
    logic            abs;  // 1 = load val into the PC, 0 = add val as signed offset
    logic [PC_W-1:0] val;
  } entry;

  // Legacy four-entry offset set, kept so existing programs run unchanged.
  localparam int OFS_BACK5 = -5;
  localparam int OFS_FWD20 = 20;
  localparam int OFS_BACK1 = -1;
  localparam int OFS_HOLD  = 0;

  // Reset offset for table slot idx; all reset entries are relative.
  // Slots beyond the legacy set hold the PC.
  function automatic int default_entry(input int idx);
    case (idx)
      0:       return OFS_BACK5;
      1:       return OFS_FWD20;
      2:       return OFS_BACK1;
      default: return OFS_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/pc_branch_table_if.sv
// Decode/fetch side bundle of the branch-target unit (branch, table write, readback, PC).
// Latency: n/a (signal bundle only).
// Backpressure: none; halt is the only stall and it acts on the PC, not the bus.
// master = decode/debug side driving requests; slave = the branch-target unit.
interface pc_branch_table_if #(
  parameter int D = 12,
  parameter int A = 3
);
  logic         halt;
  logic         br_en;
  logic [A-1:0] br_idx;
  logic         wr_en;
  logic [A-1:0] wr_idx;
  logic [D-1:0] wr_data;
  logic         wr_abs;
  logic [A-1:0] rd_idx;
  logic [D-1:0] rd_data;
  logic         rd_abs;
  logic [D-1:0] prog_ctr;
  logic         br_taken;

  modport master (
    output halt, br_en, br_idx, wr_en, wr_idx, wr_data, wr_abs, rd_idx,
    input  rd_data, rd_abs, prog_ctr, br_taken
  );

  modport slave (
    input  halt, br_en, br_idx, wr_en, wr_idx, wr_data, wr_abs, rd_idx,
    output rd_data, rd_abs, prog_ctr, br_taken
  );
endinterface

// File: rtl/pc_next_calc.sv
// Next-PC selection: halt > branch (relative add or absolute load) > increment.
// Latency: combinational, zero cycles.
// Backpressure: none; halt simply selects the current PC.
// Ports: prog_ctr/ent_abs/ent_val/halt/br_en in, nxt_pc/nxt_taken out.
module pc_next_calc #(
  parameter int D = 12
) (
  input  logic [D-1:0] prog_ctr,
  input  logic         ent_abs,
  input  logic [D-1:0] ent_val,
  input  logic         halt,
  input  logic         br_en,
  output logic [D-1:0] nxt_pc,
  output logic         nxt_taken
);

  always_comb begin
    nxt_pc    = prog_ctr;
    nxt_taken = 1'b0;
    if (halt) begin
      // Branch presented while halted is dropped, not deferred.
      nxt_pc    = prog_ctr;
      nxt_taken = 1'b0;
    end else if (br_en) begin
      // A D-bit unsigned add is the signed offset add modulo 2**D.
      nxt_pc    = ent_abs ? ent_val : prog_ctr + ent_val;
      nxt_taken = 1'b1;
    end else begin
      nxt_pc    = prog_ctr + D'(1);
      nxt_taken = 1'b0;
    end
  end

endmodule

// File: rtl/pc_branch_table.sv
// Branch-target unit: writable 2**A-entry target table plus the PC and br_taken registers.
// Latency: branch/increment one cycle to prog_ctr; table readback combinational.
// Backpressure: none; halt freezes the PC, table writes still commit.
// Ports: Clk, Reset (sync, active high), bus (slave side of pc_branch_table_if).
module pc_branch_table
  import pc_pkg::*;
#(
  parameter int          D        = 12,
  parameter int          A        = 3,
  parameter int unsigned START_PC = 0
) (
  input  logic            Clk,
  input  logic            Reset,
  pc_branch_table_if.slave bus
);

  localparam int DEPTH = 1 << A;

  typedef struct packed {
    logic         abs;
    logic [D-1:0] val;
  } tbl_entry;

  tbl_entry     tbl [DEPTH];
  tbl_entry     br_ent;
  logic [D-1:0] pc_q;
  logic         taken_q;
  logic [D-1:0] nxt_pc;
  logic         nxt_taken;

  // Branch lookup and readback both see the registered table, so a write in the
  // same cycle is not visible until the following one.
  assign br_ent       = tbl[bus.br_idx];
  assign bus.rd_data  = tbl[bus.rd_idx].val;
  assign bus.rd_abs   = tbl[bus.rd_idx].abs;
  assign bus.prog_ctr = pc_q;
  assign bus.br_taken = taken_q;

  pc_next_calc #(.D(D)) u_next_calc (
    .prog_ctr  (pc_q),
    .ent_abs   (br_ent.abs),
    .ent_val   (br_ent.val),
    .halt      (bus.halt),
    .br_en     (bus.br_en),
    .nxt_pc    (nxt_pc),
    .nxt_taken (nxt_taken)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q    <= D'(START_PC);
      taken_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '{abs: 1'b0, val: D'(default_entry(i))};
      end
    end else begin
      pc_q    <= nxt_pc;
      taken_q <= nxt_taken;
      if (bus.wr_en) begin
        tbl[bus.wr_idx] <= '{abs: bus.wr_abs, val: bus.wr_data};
      end
    end
  end

endmodule

// File: tb/tb_pc_branch_table.sv
// Scoreboard bench for pc_branch_table at D=12, A=3, START_PC=0.
// Latency: expected PC/taken pushed at drive time, popped one edge later.
// Backpressure: n/a.
module tb_pc_branch_table;

  logic clk;
  logic rst;

  pc_branch_table_if #(.D(12), .A(3)) bus ();

  pc_branch_table #(.D(12), .A(3), .START_PC(0)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct packed {
    logic [11:0] pc;
    logic        taken;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference state
  logic [11:0] m_pc;
  logic        m_taken;
  logic [11:0] m_val [8];
  logic        m_abs [8];
  bit          tbl_ok = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pc    = 12'h000;
    m_taken = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_val[i] = 12'h000;
      m_abs[i] = 1'b0;
    end
    m_val[0] = 12'hFFB;
    m_val[1] = 12'h014;
    m_val[2] = 12'hFFF;
  endtask

  task automatic step(input string tag, input logic r, input logic h, input logic be,
                      input logic [2:0] bi, input logic we, input logic [2:0] wi,
                      input logic [11:0] wd, input logic wa);
    exp_t       e;
    exp_t       g;
    logic [2:0] ri;
    @(negedge clk);
    rst         = r;
    bus.halt    = h;
    bus.br_en   = be;
    bus.br_idx  = bi;
    bus.wr_en   = we;
    bus.wr_idx  = wi;
    bus.wr_data = wd;
    bus.wr_abs  = wa;
    ri          = we ? wi : bi;
    bus.rd_idx  = ri;
    #1;
    // Readback in the drive cycle must still show the pre-write entry.
    if (tbl_ok) begin
      chk({tag, "_rd_val"}, 32'(bus.rd_data), 32'(m_val[ri]));
      chk({tag, "_rd_abs"}, 32'(bus.rd_abs), 32'(m_abs[ri]));
    end
    if (r) begin
      m_reset();
    end else begin
      if (h) begin
        m_taken = 1'b0;
      end else if (be) begin
        m_taken = 1'b1;
        if (m_abs[bi]) m_pc = m_val[bi];
        else           m_pc = m_pc + m_val[bi];
      end else begin
        m_taken = 1'b0;
        m_pc    = m_pc + 12'd1;
      end
      if (we) begin
        m_val[wi] = wd;
        m_abs[wi] = wa;
      end
    end
    e.pc    = m_pc;
    e.taken = m_taken;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    tbl_ok = 1;
    g = sbq.pop_front();
    chk({tag, "_pc"}, 32'(bus.prog_ctr), 32'(g.pc));
    chk({tag, "_taken"}, 32'(bus.br_taken), 32'(g.taken));
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 12'h000, 1'b0);
  endtask

  task automatic branch(input string tag, input logic [2:0] bi);
    step(tag, 1'b0, 1'b0, 1'b1, bi, 1'b0, 3'd0, 12'h000, 1'b0);
  endtask

  // Readback checks against fixed values; taken between edges, no clock passes.
  task automatic rdchk(input string tag, input logic [2:0] idx,
                       input logic [11:0] ev, input logic ea);
    bus.rd_idx = idx;
    #1;
    chk({tag, "_val"}, 32'(bus.rd_data), 32'(ev));
    chk({tag, "_abs"}, 32'(bus.rd_abs), 32'(ea));
  endtask

  logic [11:0] dflt [8];

  initial begin
    rst         = 1'b1;
    bus.halt    = 1'b0;
    bus.br_en   = 1'b0;
    bus.br_idx  = 3'd0;
    bus.wr_en   = 1'b0;
    bus.wr_idx  = 3'd0;
    bus.wr_data = 12'h000;
    bus.wr_abs  = 1'b0;
    bus.rd_idx  = 3'd0;
    m_reset();
    dflt[0] = 12'hFFB; dflt[1] = 12'h014; dflt[2] = 12'hFFF;
    for (int i = 3; i < 8; i++) dflt[i] = 12'h000;

    // Reset state and legacy table contents
    step("reset", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 12'h000, 1'b0);
    for (int i = 0; i < 4; i++) rdchk($sformatf("dflt%0d", i), 3'(i), dflt[i], 1'b0);

    // Free-running increment 1..4
    for (int i = 0; i < 4; i++) idle($sformatf("inc%0d", i));

    // Relative branches, including wrap below zero and wrap over the top
    branch("br_m1", 3'd2);
    branch("br_m5_wrap", 3'd0);
    idle("inc_fff");
    idle("inc_wrap0");

    // Absolute entry, then rewritten as relative (write under halt)
    step("wr5_abs", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd5, 12'd100, 1'b1);
    branch("br5_abs", 3'd5);
    rdchk("rd5", 3'd5, 12'd100, 1'b1);
    step("wr5_rel_halt", 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd5, 12'd8, 1'b0);
    branch("br5_rel", 3'd5);

    // Same-cycle write and branch to one index uses the old entry
    step("wr6_halt", 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd6, 12'd10, 1'b1);
    branch("br6_to10", 3'd6);
    step("wr1_br1", 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 3'd1, 12'd7, 1'b0);
    branch("br1_new", 3'd1);

    // Halt drops a branch; write during halt still commits
    step("wr7_halt", 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd7, 12'd50, 1'b1);
    branch("br7_to50", 3'd7);
    step("halt_br_wr3", 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 3'd3, 12'h123, 1'b1);
    rdchk("rd3_after_halt", 3'd3, 12'h123, 1'b1);

    // Relative zero holds the PC but still signals taken
    branch("br4_hold", 3'd4);

    // Mid-run reset discards the concurrent write and branch
    step("reset_mid", 1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 3'd0, 12'h555, 1'b1);
    for (int i = 0; i < 8; i++) rdchk($sformatf("post_rst%0d", i), 3'(i), dflt[i], 1'b0);
    idle("post_rst_inc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_branch_table.md
Name: pc_branch_table

Overview:
- Next-generation branch-target unit: parametrised-depth, run-time-writable target table combined with the program-counter register.
- Each entry holds a D-bit value and a mode bit: relative (signed offset added to the PC) or absolute (loaded into the PC directly).
- Sits between instruction decode (branch request and table index) and instruction fetch (PC output).
- Table reloads the legacy 4-entry offset set on reset, so existing programs run unchanged.

Parameters:
- D, 12, PC and table-entry width in bits; all PC arithmetic is modulo 2**D.
- A, 3, table index width; depth is 2**A entries; A >= 2 required.
- START_PC, 0, PC value loaded on reset.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- halt  input  1  freeze the PC this cycle.
- br_en  input  1  take a branch via table entry br_idx this cycle.
- br_idx  input  A  table index for the branch.
- wr_en  input  1  write table entry wr_idx.
- wr_idx  input  A  table index to write.
- wr_data  input  D  value to write (two's-complement offset or absolute address).
- wr_abs  input  1  mode to write: 1 = absolute, 0 = relative.
- rd_idx  input  A  debug readback index.
- rd_data  output  D  combinational value of entry rd_idx.
- rd_abs  output  1  combinational mode of entry rd_idx.
- prog_ctr  output  D  registered current PC.
- br_taken  output  1  registered; 1 for the cycle after a branch updated the PC.

Behaviour:
- Reset (synchronous, highest priority):
  - prog_ctr <= START_PC; br_taken <= 0.
  - Entry 0 <= relative -5 (1111_1111_1011 at D=12); entry 1 <= relative +20; entry 2 <= relative -1 (all ones); entry 3 and all higher entries <= relative 0 (hold).
  - All other inputs are ignored during a Reset cycle, including wr_en.
  - Reset asserted mid-run discards any write or branch presented that cycle.
- PC update priority when Reset = 0: halt > br_en > increment.
  - halt = 1: prog_ctr holds; br_taken <= 0; br_en is ignored (the branch is dropped, not queued).
  - br_en = 1 with relative entry: prog_ctr <= (prog_ctr + value) mod 2**D, value treated as signed.
  - br_en = 1 with absolute entry: prog_ctr <= value.
  - In both branch cases br_taken <= 1.
  - Otherwise: prog_ctr <= (prog_ctr + 1) mod 2**D; br_taken <= 0.
- Wrap-around: 0 + (-5) yields 2**D - 5; (2**D - 1) + 1 yields 0. No overflow flag.
- A relative-0 branch holds the PC but still raises br_taken.
- Table writes:
  - Take effect on the clock edge; visible on rd_data and to branches from the next cycle.
  - Performed regardless of halt.
- Simultaneous write and branch to the same index: the branch uses the OLD entry (no write-to-branch bypass). rd_data likewise shows the old value in that cycle.
- Latency: branch or increment is one cycle from input to prog_ctr; readback is combinational (zero cycles).
- No X propagation: every entry is defined from the first post-reset cycle.

Decomposition:
- Package pc_pkg:
  - entry typedef (struct: logic abs; logic [D-1:0] val).
  - Legacy default constants OFS_BACK5 = -5, OFS_FWD20 = 20, OFS_BACK1 = -1, OFS_HOLD = 0.
  - Function default_entry(idx) returning the reset contents.
- Sub-module pc_next_calc (combinational):
  - Inputs: prog_ctr, selected entry, halt, br_en.
  - Outputs: next PC and taken; encapsulates priority and modulo arithmetic.
- Top level holds the table array, write port, PC register and br_taken register.

Test Plan:
- Reset, release, 4 idle cycles -> prog_ctr 0,1,2,3,4; br_taken 0 throughout; rd_idx 0..3 read back FFB/0, 014/0, FFF/0, 000/0 (value/abs) at D=12.
- At prog_ctr = 4, br_en with br_idx = 2 -> next prog_ctr = 3, br_taken = 1 for one cycle; then br_idx = 0 -> prog_ctr = 3 - 5 = 0xFFE (wrap).
- Write entry 5 = 100, abs = 1; next cycle br_en, br_idx = 5 -> prog_ctr = 100; then write entry 5 = +8 relative and branch -> 108.
- Same cycle: wr_en on idx 1 with 7 (relative) and br_en idx 1 at prog_ctr = 10 -> prog_ctr = 30 (old +20); a repeat branch next cycle -> 37.
- halt with br_en at prog_ctr = 50 -> prog_ctr stays 50, br_taken = 0; a write presented during halt is committed and reads back next cycle.
- Reset asserted mid-run together with wr_en and br_en -> prog_ctr = START_PC, br_taken = 0, all entries back to defaults, write discarded.
